// File: rtl/mem_pkg.sv
// mem_pkg: shared constants, state encoding and alignment
// helper for mem_access_ctrl and the RAM model.
package mem_pkg;

  localparam logic [1:0] BYTE  = 2'b00;
  localparam logic [1:0] HALF  = 2'b01;
  localparam logic [1:0] WORD  = 2'b10;
  localparam logic [1:0] DWORD = 2'b11;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam logic ENABLE = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    WAIT,
    RECOVER,
    DONE
  } state_t;

  function automatic logic is_aligned(
    input logic [1:0] dt,
    input logic [2:0] a
  );
    logic r;
    unique case (dt)
      HALF:    r = ~a[0];
      WORD:    r = (a[1:0] == 2'b00);
      DWORD:   r = (a[2:0] == 3'b000);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: SYNC_STAGES-deep flop chain for an async level.
// Ports: clk, rst_n (sync, active low), d (async in), q (synced).
module sync_2ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[SYNC_STAGES-1];

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: CPU-side master for the 256-byte RAM mfa/mfc
// handshake. CPU: req/rw/dtype/addr/wdata -> busy/done/err/rdata.
// RAM: mem_* outputs, mem_mfc/mem_data_out inputs.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  dtype,
  input  logic [7:0]  addr,
  input  logic [63:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] rdata,
  output logic        mem_enable,
  output logic        mem_r_w,
  output logic        mem_mfa,
  output logic        mem_dwp1,
  output logic [1:0]  mem_dtype,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_data_in,
  input  logic        mem_mfc,
  input  logic [31:0] mem_data_out
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MIN = CW'(SYNC_STAGES);

  state_t state, state_n;

  logic        rw_q;
  logic [1:0]  dtype_q;
  logic [7:0]  addr_q;
  logic [63:0] wdata_q;
  logic        beat;
  logic        err_q;
  logic [CW-1:0] cnt;
  logic [63:0] rdata_q;

  logic mfc_s;
  logic start;
  logic ok;
  logic acc;
  logic tmo;
  logic hi_beat;

  sync_2ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (mem_mfc),
    .q    (mfc_s)
  );

  assign ok    = is_aligned(dtype, addr[2:0]);
  assign start = (state == IDLE) && req;

  // The first SYNC_STAGES cycles of WAIT only flush a level
  // left over from the previous access out of the synchronizer.
  assign acc = (state == WAIT) && mfc_s
            && (cnt >= CNT_MIN);
  assign tmo = (state == WAIT) && !acc
            && (cnt == CNT_MAX);

  assign hi_beat = (dtype_q == DWORD) && !beat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (req) begin
          state_n = ok ? SETUP : DONE;
        end
      end
      SETUP: state_n = WAIT;
      WAIT: begin
        if (acc) begin
          state_n = RECOVER;
        end else if (tmo) begin
          state_n = DONE;
        end
      end
      RECOVER: begin
        state_n = hi_beat ? SETUP : DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rw_q    <= READ;
      dtype_q <= BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      beat    <= 1'b0;
      err_q   <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      if (start) begin
        rw_q    <= rw;
        dtype_q <= dtype;
        addr_q  <= addr;
        wdata_q <= wdata;
        beat    <= 1'b0;
        err_q   <= ~ok;
      end
      if (state == RECOVER && hi_beat) begin
        beat <= 1'b1;
      end
      if (state == DONE) begin
        beat <= 1'b0;
      end
      if (state == WAIT) begin
        if (cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
      if (tmo) begin
        err_q <= 1'b1;
      end
      if (acc && rw_q == READ) begin
        if (hi_beat) begin
          rdata_q[63:32] <= mem_data_out;
        end else begin
          rdata_q[31:0] <= mem_data_out;
          if (dtype_q != DWORD) begin
            rdata_q[63:32] <= '0;
          end
        end
      end
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign err   = done && err_q;
  assign rdata = rdata_q;

  assign mem_enable = (state == SETUP
                    || state == WAIT
                    || state == RECOVER)
                    ? ENABLE : ~ENABLE;
  assign mem_mfa     = (state == WAIT);
  assign mem_r_w     = rw_q;
  assign mem_dwp1    = ~beat;
  assign mem_dtype   = dtype_q;
  assign mem_addr    = addr_q;
  assign mem_data_in = hi_beat ? wdata_q[63:32]
                               : wdata_q[31:0];

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed + random transfers against a
// byte-array RAM model and a byte-level reference memory.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  localparam int TMO = 8;
  localparam int SYN = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        rw = 1'b0;
  logic [1:0]  dtype = 2'b00;
  logic [7:0]  addr = 8'h00;
  logic [63:0] wdata = 64'h0;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] rdata;
  logic        mem_enable;
  logic        mem_r_w;
  logic        mem_mfa;
  logic        mem_dwp1;
  logic [1:0]  mem_dtype;
  logic [7:0]  mem_addr;
  logic [31:0] mem_data_in;
  logic        mem_mfc;
  logic [31:0] mem_data_out;

  int n_vec = 0;
  int n_err = 0;

  bit mute = 1'b0;
  int ram_dly = 0;
  int stale_cnt = 0;
  int en_cnt = 0;
  logic beat_dwp[$];
  int   gap_log[$];

  logic [7:0]  ref_mem[256];
  logic [63:0] ref_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl #(
    .TIMEOUT    (TMO),
    .SYNC_STAGES(SYN)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .rw          (rw),
    .dtype       (dtype),
    .addr        (addr),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .rdata       (rdata),
    .mem_enable  (mem_enable),
    .mem_r_w     (mem_r_w),
    .mem_mfa     (mem_mfa),
    .mem_dwp1    (mem_dwp1),
    .mem_dtype   (mem_dtype),
    .mem_addr    (mem_addr),
    .mem_data_in (mem_data_in),
    .mem_mfc     (mem_mfc),
    .mem_data_out(mem_data_out)
  );

  function automatic logic [7:0] init_byte(input int i);
    return 8'(i * 29 + 7) ^ 8'h5A;
  endfunction

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Big-endian byte RAM; dword beat1 (dwp1=0) is addr+4.
  logic [7:0] ram[256];

  task automatic ram_access();
    logic [7:0] a;
    int nb;
    a = mem_addr;
    if (mem_dtype == DWORD && !mem_dwp1) a = a + 8'd4;
    nb = (mem_dtype == BYTE) ? 1 :
         (mem_dtype == HALF) ? 2 : 4;
    if (mem_r_w == WRITE) begin
      for (int i = 0; i < nb; i++)
        ram[8'(a + i)] = mem_data_in[8*(nb-1-i) +: 8];
    end else begin
      mem_data_out = '0;
      for (int i = 0; i < nb; i++)
        mem_data_out[8*(nb-1-i) +: 8] = ram[8'(a + i)];
    end
    beat_dwp.push_back(mem_dwp1);
  endtask

  initial begin : ram_model
    int wait_n;
    int stale_seen;
    int lo_cnt;
    int last_gap;
    bit served;
    bit mfa_prev;
    wait_n = 0;
    stale_seen = 0;
    lo_cnt = 0;
    last_gap = 0;
    served = 1'b0;
    mfa_prev = 1'b0;
    mem_mfc = 1'b0;
    mem_data_out = 32'h0;
    for (int i = 0; i < 256; i++) ram[i] = init_byte(i);
    forever begin
      @(negedge clk);
      if (!mem_enable) en_cnt++;
      if (!mem_mfa) lo_cnt++;
      else if (!mfa_prev) begin
        last_gap = lo_cnt;
        lo_cnt = 0;
      end
      mfa_prev = mem_mfa;
      if (stale_cnt != stale_seen) begin
        if (mem_mfa) begin
          stale_seen = stale_cnt;
          mem_mfc = 1'b0;
          served = 1'b0;
          wait_n = ram_dly;
        end else begin
          mem_mfc = 1'b1;
          mem_data_out = 32'hBAD0_BAD0;
        end
      end else if (!mem_mfa || mem_enable) begin
        mem_mfc = 1'b0;
        served = 1'b0;
        wait_n = ram_dly;
      end else if (!served && !mute) begin
        if (wait_n == 0) begin
          ram_access();
          gap_log.push_back(last_gap);
          mem_mfc = 1'b1;
          served = 1'b1;
        end else begin
          wait_n--;
        end
      end
    end
  end

  // n counts edges after the accepting edge k at which done is
  // first seen high; done sampled at edge k+n+1 in the plan.
  task automatic txn(
    input logic        w,
    input logic [1:0]  dt,
    input logic [7:0]  a,
    input logic [63:0] wd,
    input int          dly,
    input bit          tmo,
    input bit          stl
  );
    bit ok;
    int nb;
    int n;
    int b0;
    int e0;
    logic [63:0] val;
    ok = (dt == HALF)  ? (a[0] == 1'b0) :
         (dt == WORD)  ? (a[1:0] == 2'b00) :
         (dt == DWORD) ? (a[2:0] == 3'b000) : 1'b1;
    nb = 1 << dt;
    if (ok && !tmo) begin
      if (w == WRITE) begin
        for (int i = 0; i < nb; i++)
          ref_mem[8'(a + i)] = wd[8*(nb-1-i) +: 8];
      end else begin
        val = '0;
        for (int i = 0; i < nb; i++)
          val = {val[55:0], ref_mem[8'(a + i)]};
        ref_rdata = val;
      end
    end
    ram_dly = dly;
    mute = tmo;
    if (stl) begin
      stale_cnt++;
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    b0 = beat_dwp.size();
    e0 = en_cnt;
    req = 1'b1;
    rw = w;
    dtype = dt;
    addr = a;
    wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0;
    rw = 1'($urandom);
    dtype = 2'($urandom);
    addr = 8'($urandom);
    wdata = {$urandom, $urandom};
    check("busy_k", busy, 1);
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!done) begin
      check("done_seen", 0, 1);
      return;
    end
    check("err", err, !ok || tmo);
    check("rdata", rdata, ref_rdata);
    if (!ok) begin
      check("lat_misalign", n, 0);
      check("enable_untouched", en_cnt - e0, 0);
    end else if (tmo) begin
      check("lat_timeout", n, TMO + 2);
    end else if (stl) begin
      check("stale_wait", n >= 6, 1);
    end else if (dly == 0) begin
      if (dt == DWORD)
        check("lat_dword", n == 9 || n == 10, 1);
      else
        check("lat_single", n, 5);
    end
    if (ok && !tmo) begin
      check("beats", beat_dwp.size() - b0,
            (dt == DWORD) ? 2 : 1);
      if (dt == DWORD && beat_dwp.size() - b0 == 2) begin
        check("dwp1_b0", beat_dwp[b0], 1);
        check("dwp1_b1", beat_dwp[b0+1], 0);
        check("mfa_gap", gap_log[b0+1] >= 1, 1);
      end
    end
    @(posedge clk);
    #1;
    check("done_pulse", done, 0);
    check("busy_idle", busy, 0);
    check("mfa_idle", mem_mfa, 0);
    check("enable_idle", mem_enable, 1);
  endtask

  task automatic reset_mid_dword();
    int n;
    mute = 1'b1;
    @(negedge clk);
    req = 1'b1;
    rw = READ;
    dtype = DWORD;
    addr = 8'h20;
    @(posedge clk);
    #1;
    req = 1'b0;
    n = 0;
    while (!mem_mfa && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rst_in_wait", mem_mfa, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    ref_rdata = '0;
    check("rst_mfa", mem_mfa, 0);
    check("rst_enable", mem_enable, 1);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, ref_rdata);
    @(negedge clk);
    rst_n = 1'b1;
    mute = 1'b0;
  endtask

  initial begin : main
    logic [1:0]  dt;
    logic [7:0]  a;
    logic [7:0]  mask;
    int          dly;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_byte(i);
    ref_rdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy0", busy, 0);
    check("rst_done0", done, 0);
    check("rst_err0", err, 0);
    check("rst_rdata0", rdata, 0);
    check("rst_en0", mem_enable, 1);
    check("rst_mfa0", mem_mfa, 0);
    check("rst_rw0", mem_r_w, 0);
    check("rst_dwp1", mem_dwp1, 1);
    check("rst_dtype0", mem_dtype, 0);
    check("rst_addr0", mem_addr, 0);
    check("rst_din0", mem_data_in, 0);
    @(negedge clk);
    rst_n = 1'b1;

    txn(WRITE, WORD, 8'h10, 64'hDEADBEEF, 0, 0, 0);
    txn(READ, WORD, 8'h10, 64'h0, 0, 0, 0);
    check("word_rd", rdata, 64'h00000000_DEADBEEF);
    txn(WRITE, DWORD, 8'h20, 64'h11223344_55667788,
        0, 0, 0);
    txn(READ, DWORD, 8'h20, 64'h0, 0, 0, 0);
    check("dword_rd", rdata, 64'h11223344_55667788);
    txn(WRITE, BYTE, 8'h03, 64'hA5, 0, 0, 0);
    txn(READ, HALF, 8'h02, 64'h0, 0, 0, 0);
    check("half_lo", rdata[7:0], 8'hA5);
    txn(READ, HALF, 8'h03, 64'h0, 0, 0, 0);
    txn(READ, WORD, 8'h14, 64'h0, 0, 1, 0);
    txn(READ, WORD, 8'h10, 64'h0, 0, 0, 1);
    reset_mid_dword();
    txn(READ, WORD, 8'h10, 64'h0, 0, 0, 0);

    repeat (80) begin
      dt = 2'($urandom);
      mask = (dt == HALF)  ? 8'hFE :
             (dt == WORD)  ? 8'hFC :
             (dt == DWORD) ? 8'hF8 : 8'hFF;
      a = 8'($urandom);
      if ($urandom_range(0, 3) != 0) a = a & mask;
      dly = $urandom_range(0, 3);
      txn(1'($urandom), dt, a, {$urandom, $urandom},
          dly, 0, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
